// File: rtl/mips_mem_pkg.sv
// Shared constants for the MIPS data-memory path: access sizes, default base address and
// FaultStatus bit positions.
package mips_mem_pkg;

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  localparam logic [31:0] DEFAULT_BASE_ADDRESS = 32'h1001_0000;

  localparam int unsigned FS_MISALIGNED = 0;
  localparam int unsigned FS_RANGE      = 1;
  localparam int unsigned FS_ILLEGAL    = 2;
  localparam int unsigned FS_WIDTH      = 3;

endpackage

// File: rtl/sized_data_memory_if.sv
// MEM-stage request/response bundle between the datapath (master) and the data memory (slave).
interface sized_data_memory_if;

  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [1:0]  AccessSize;
  logic        LoadUnsigned;
  logic        FaultClear;
  logic [31:0] ReadData;
  logic        ReadValid;
  logic        Fault;
  logic [2:0]  FaultStatus;

  modport master (
    output Address, WriteData, MemWrite, MemRead, AccessSize, LoadUnsigned, FaultClear,
    input  ReadData, ReadValid, Fault, FaultStatus
  );

  modport slave (
    input  Address, WriteData, MemWrite, MemRead, AccessSize, LoadUnsigned, FaultClear,
    output ReadData, ReadValid, Fault, FaultStatus
  );

endinterface

// File: rtl/load_align_extend.sv
// Selects the addressed byte/halfword lane from a 32-bit word and sign- or zero-extends it.
// Pure combinational so it can be shared with the cache refill path.
module load_align_extend
  import mips_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        zero_ext,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? word[31:16] : word[15:0];
    data     = '0;
    case (size)
      SIZE_BYTE: data = {{24{~zero_ext & byte_sel[7]}}, byte_sel};
      SIZE_HALF: data = {{16{~zero_ext & half_sel[15]}}, half_sel};
      SIZE_WORD: data = word;
      default:   data = '0;
    endcase
  end

endmodule

// File: rtl/sized_data_memory.sv
// Byte-addressable word RAM for the MEM stage: sized stores with byte enables, one-cycle
// registered loads, and misaligned / out-of-range / illegal request detection.
module sized_data_memory
  import mips_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MEMORY_DEPTH = 1024,
  parameter logic [31:0] BASE_ADDRESS = DEFAULT_BASE_ADDRESS
) (
  input logic               clk,
  input logic               reset,
  sized_data_memory_if.slave bus
);

  localparam int unsigned IdxWidth = $clog2(MEMORY_DEPTH);
  localparam int unsigned NumLanes = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

  logic [29:0]         word_off;
  logic [IdxWidth-1:0] idx;
  logic [1:0]          lane;
  logic                below_base;
  logic                out_of_range;
  logic                misaligned;
  logic                illegal;
  logic                request;
  logic [FS_WIDTH-1:0] fault_flags;
  logic                fault;
  logic                do_write;
  logic                do_read;
  logic [3:0]          byte_en;
  logic [31:0]         wdata_rep;

  logic [31:0]         rd_word_q;
  logic [1:0]          rd_lane_q;
  logic [1:0]          rd_size_q;
  logic                rd_zext_q;
  logic                valid_q;
  logic                fault_q;
  logic [FS_WIDTH-1:0] status_q;
  logic [31:0]         load_data;

  // Word offset is taken on the word-address bits so the base must be word aligned; the explicit
  // below-base test stops a wrapped subtraction from landing back in range.
  always_comb begin
    lane         = bus.Address[1:0];
    below_base   = bus.Address < BASE_ADDRESS;
    word_off     = bus.Address[31:2] - BASE_ADDRESS[31:2];
    idx          = word_off[IdxWidth-1:0];
    out_of_range = below_base || (word_off >= 30'(MEMORY_DEPTH));
    request      = bus.MemRead || bus.MemWrite;
    illegal      = (bus.MemRead && bus.MemWrite) || (bus.AccessSize == SIZE_ILLEGAL);
    misaligned   = ((bus.AccessSize == SIZE_HALF) && lane[0]) ||
                   ((bus.AccessSize == SIZE_WORD) && (lane != 2'b00));

    fault_flags                = '0;
    fault_flags[FS_MISALIGNED] = request && misaligned;
    fault_flags[FS_RANGE]      = request && out_of_range;
    fault_flags[FS_ILLEGAL]    = request && illegal;
    fault                      = |fault_flags;

    do_write = bus.MemWrite && !fault && !reset;
    do_read  = bus.MemRead && !fault;
  end

  // Store data is replicated across lanes so each enabled lane just takes its own slice.
  always_comb begin
    byte_en   = 4'b1111;
    wdata_rep = bus.WriteData;
    case (bus.AccessSize)
      SIZE_BYTE: begin
        byte_en   = 4'b0001 << lane;
        wdata_rep = {4{bus.WriteData[7:0]}};
      end
      SIZE_HALF: begin
        byte_en   = lane[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{bus.WriteData[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < NumLanes; b++) begin
        if (byte_en[b]) begin
          mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
        end
      end
    end
  end

  // Read-side state only moves on MemRead, which is what holds ReadData between loads.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_word_q <= '0;
      rd_lane_q <= '0;
      rd_size_q <= SIZE_WORD;
      rd_zext_q <= 1'b0;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
      status_q  <= '0;
    end else begin
      valid_q  <= bus.MemRead;
      fault_q  <= fault;
      status_q <= (bus.FaultClear ? '0 : status_q) | fault_flags;
      if (bus.MemRead) begin
        rd_word_q <= do_read ? mem[idx] : '0;
        rd_lane_q <= lane;
        rd_size_q <= bus.AccessSize;
        rd_zext_q <= bus.LoadUnsigned;
      end
    end
  end

  load_align_extend u_align (
    .word    (rd_word_q),
    .lane    (rd_lane_q),
    .size    (rd_size_q),
    .zero_ext(rd_zext_q),
    .data    (load_data)
  );

  assign bus.ReadData    = load_data;
  assign bus.ReadValid   = valid_q;
  assign bus.Fault       = fault_q;
  assign bus.FaultStatus = status_q;

endmodule

// File: doc/sized_data_memory.md
# sized_data_memory

Word-organised, byte-addressable data memory for the MIPS datapath's MEM stage. Supports byte, halfword and word loads and stores, with sign or zero extension on loads. Reads are synchronous with one cycle of latency, so the block fits the pipeline's MEM/WB register boundary. Misaligned and out-of-range accesses are detected, suppressed and reported through both a per-access pulse and sticky status bits.

## Interface
Parameters:
- DATA_WIDTH, 32: word width in bits; must be 32.
- MEMORY_DEPTH, 1024: number of words; must be a power of two.
- BASE_ADDRESS, 32'h1001_0000: byte address of word 0.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- Address  in  32  byte address of the access.
- WriteData  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- MemWrite  in  1  store request this cycle.
- MemRead  in  1  load request this cycle.
- AccessSize  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- LoadUnsigned  in  1  1 = zero-extend a sub-word load, 0 = sign-extend it.
- FaultClear  in  1  clears FaultStatus.
- ReadData  out  32  extended load result.
- ReadValid  out  1  one-cycle pulse, one cycle after an accepted MemRead.
- Fault  out  1  one-cycle pulse, one cycle after any faulting request.
- FaultStatus  out  3  sticky flags: [0] misaligned, [1] out of range, [2] illegal request.

## Operation
- Word index = (Address − BASE_ADDRESS) >> 2. Byte lane = Address[1:0].
- Out of range: Address < BASE_ADDRESS, or word index ≥ MEMORY_DEPTH. Address arithmetic is 32-bit unsigned, with no wrap into range.
- Misaligned: a halfword access with Address[0] = 1, or a word access with Address[1:0] ≠ 0.
- Illegal request: MemRead and MemWrite both high, or AccessSize = 11 with either one high.
- A faulting request makes no memory change. A faulting read returns ReadData = 0 with ReadValid = 1. A faulting write gives no ReadValid.
- Store byte enables:
  - byte: one lane, WriteData[7:0] placed on that lane;
  - halfword: lanes {1,0} or {3,2}, WriteData[15:0];
  - word: all four lanes.
  - Unselected lanes keep their old contents.
- Load: the addressed lane(s) are selected from the registered word, then extended per LoadUnsigned. LoadUnsigned is ignored for word loads.
- FaultStatus bits OR in on each Fault. A bit set in the same cycle as FaultClear stays set (set wins).
- With neither request high, the memory holds its contents and no outputs pulse.

## Timing
- Request sampled at edge N. The write takes effect at edge N. ReadData, ReadValid and Fault are registered and valid in cycle N+1.
- Read at N returns the array contents from before edge N. A store at N followed by a load at N+1 to the same word returns the new data in N+2.
- A request can be accepted every cycle; back-to-back reads give consecutive ReadValid pulses.
- ReadData holds its last value while ReadValid = 0.
- Reset values: ReadData 0, ReadValid 0, Fault 0, FaultStatus 0. Memory contents are not reset.
- Reset asserted in the cycle after a read: the pending ReadValid and Fault are dropped, and outputs go to their reset values.
- A request present during reset is ignored, with no write.

## Structure
- Shared package `mips_mem_pkg`:
  - access-size constants SIZE_BYTE, SIZE_HALF, SIZE_WORD;
  - BASE_ADDRESS default;
  - FaultStatus bit indices.
- Sub-module `load_align_extend`: combinational lane select plus sign or zero extension from (word, lane, size, unsigned). It is reused by the later cache refill path.
- Top level holds the RAM array, byte-enable write, request decode, fault logic and output registers.

## Test plan
- Store word 0xDEADBEEF at 0x1001_0000, then load word at the same address: ReadData = 0xDEADBEEF with ReadValid high one cycle after the load.
- Store word 0x11223344 at 0x1001_0004, then store byte 0x80 at 0x1001_0005. Then:
  - signed byte load at 0x1001_0005 → 0xFFFF_FF80;
  - unsigned byte load → 0x0000_0080;
  - word load at 0x1001_0004 → 0x1122_8044.
- Halfword load at 0x1001_0003 → Fault pulse, FaultStatus = 3'b001, ReadData 0, memory unchanged. Assert FaultClear → FaultStatus returns to 0.
- Word store at BASE_ADDRESS + 4·MEMORY_DEPTH, and at 0x1000_FFFC → Fault on both, FaultStatus[1] set, neighbouring words unchanged.
- MemRead and MemWrite both high → Fault with FaultStatus[2] set, no write. Reset in the cycle after a valid read → no ReadValid pulse, all outputs 0.
- Alternate store/load to the same word every cycle for 16 cycles → each load returns the value written by the store immediately before it.
